qq_ctrl: RTL and testbench

QQ_CTRL -- requirements
Module: qq_ctrl

---
 rtl/qq_pkg.sv | 6 +
 rtl/qq_ctrl.sv | 81 ++++++++
 tb/tb_qq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qq_pkg.sv
// qq_pkg: FSM state and op encodings shared by the queue-chain controller
package qq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_RESP} qq_state_e;
  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;
endpackage

// File: rtl/qq_ctrl.sv
// qq_ctrl: host request/response front end that drives a two-node queue chain
// Ports: clk/rst (async active-high); req_* host request handshake (op, data);
// rsp_* host response handshake (data, err); q_* strobes, data and status of
// the attached chain; cnt_o occupancy tracked by the controller.
module qq_ctrl
  import qq_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4,
  localparam int CAP = 2 * D,
  localparam int CW = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [W-1:0]  req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_err,
  output logic          q_enq,
  output logic          q_deq,
  output logic [W-1:0]  q_data_o,
  input  logic [W-1:0]  q_data_i,
  input  logic          q_full,
  input  logic          q_empty,
  input  logic          q_rdy,
  output logic [CW-1:0] cnt_o
);
  qq_state_e state, state_n;
  logic op_r;
  logic [W-1:0] data_r;
  logic accept;
  logic issue_err;
  assign req_ready = !rst && state == ST_IDLE && q_rdy;
  assign accept = req_valid && req_ready;
  assign issue_err = op_r == OP_ENQ ? q_full : q_empty;
  assign q_enq = state == ST_ISSUE && op_r == OP_ENQ && !q_full;
  assign q_deq = state == ST_ISSUE && op_r == OP_DEQ && !q_empty;
  assign q_data_o = (state == ST_ISSUE && op_r == OP_ENQ) ? data_r : '0;
  assign rsp_valid = state == ST_RESP;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   state_n = accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:  state_n = issue_err ? ST_RESP : ST_SETTLE;
      ST_SETTLE: state_n = q_rdy ? ST_RESP : ST_SETTLE;
      ST_RESP:   state_n = rsp_ready ? ST_IDLE : ST_RESP;
      default:   state_n = ST_IDLE;
    endcase
  end
  // Response fields are cleared at acceptance so an enqueue or a rejected
  // request always answers with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_r     <= OP_ENQ;
      data_r   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      cnt_o    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_r     <= req_op;
        data_r   <= req_data;
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
      if (state == ST_ISSUE) rsp_err <= issue_err;
      if (q_deq) rsp_data <= q_data_i;
      if (q_enq && cnt_o != CW'(CAP)) cnt_o <= cnt_o + 1'b1;
      else if (q_deq && cnt_o != '0) cnt_o <= cnt_o - 1'b1;
    end
  end
  // The chain's full/empty flags should make saturation unreachable.
  assert property (@(posedge clk) disable iff (rst)
    !(q_enq && cnt_o == CW'(CAP)) && !(q_deq && cnt_o == '0));
endmodule

// File: tb/tb_qq_ctrl.sv
// tb_qq_ctrl: randomized self-checking bench for qq_ctrl against a queue model
module tb_qq_ctrl;
  import qq_pkg::*;
  localparam int W = 32;
  localparam int D = 4;
  localparam int CAP = 2 * D;
  localparam int CW = $clog2(CAP + 1);
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0, req_op = 0, rsp_ready = 0;
  logic [W-1:0] req_data = '0;
  logic req_ready, rsp_valid, rsp_err, q_enq, q_deq, q_full, q_empty, q_rdy;
  logic [W-1:0] rsp_data, q_data_o, q_data_i;
  logic [CW-1:0] cnt_o;
  logic rdy_hold = 1, rdy_rnd = 1, rnd_on = 0;
  int n_cmp = 0, n_bad = 0, mon_bad = 0, n_enq = 0, n_deq = 0;
  logic [W-1:0] ref_q[$];
  logic [W-1:0] cmem[CAP];
  logic [2:0] ch_h = '0;
  logic [3:0] ch_n = '0;

  qq_ctrl #(.W(W), .D(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .q_enq(q_enq), .q_deq(q_deq), .q_data_o(q_data_o), .q_data_i(q_data_i),
    .q_full(q_full), .q_empty(q_empty), .q_rdy(q_rdy), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;
  assign q_rdy = rdy_hold & rdy_rnd;
  always @(negedge clk) rdy_rnd <= rnd_on ? ($urandom_range(0, 3) != 0) : 1'b1;

  // Stand-in for the two-node chain: an 8-entry FIFO.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_h <= '0;
      ch_n <= '0;
    end else begin
      if (q_enq) cmem[3'(ch_h + ch_n[2:0])] <= q_data_o;
      if (q_deq) ch_h <= ch_h + 3'd1;
      ch_n <= ch_n + {3'b0, q_enq} - {3'b0, q_deq};
    end
  end
  assign q_full = ch_n == 4'd8;
  assign q_empty = ch_n == 4'd0;
  assign q_data_i = q_empty ? '0 : cmem[ch_h];

  always @(negedge clk) begin
    if (!rst) begin
      if (q_enq && q_deq) mon_bad <= mon_bad + 1;
      n_enq <= n_enq + (q_enq ? 1 : 0);
      n_deq <= n_deq + (q_deq ? 1 : 0);
    end
  end

  function automatic void ref_apply(input logic op, input logic [W-1:0] d,
                                    output logic [W-1:0] ed, output logic ee);
    ed = '0;
    ee = 1'b0;
    if (op == OP_ENQ) begin
      if (ref_q.size() == CAP) ee = 1'b1;
      else ref_q.push_back(d);
    end else begin
      if (ref_q.size() == 0) ee = 1'b1;
      else ed = ref_q.pop_front();
    end
  endfunction

  task automatic accept(input logic op, input logic [W-1:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_data = d;
    #1;
    while (!req_ready && t < 200) begin
      @(negedge clk); #1; t++;
    end
    n_cmp++;
    if (!req_ready) begin
      n_bad++;
      $display("FAIL accept_timeout req_ready=%b want 1", req_ready);
      req_valid = 0;
    end else begin
      @(posedge clk); #1;
      req_valid = 0; req_op = ~op; req_data = ~d;
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk); #1; lat++;
    end while (!rsp_valid && lat < 100);
    n_cmp++;
    if (!rsp_valid) begin
      n_bad++;
      $display("FAIL rsp_timeout rsp_valid=%b want 1", rsp_valid);
    end
  endtask

  task automatic take_rsp(input int hold, input logic [W-1:0] d, input logic e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (!rsp_valid || rsp_data !== d || rsp_err !== e || req_ready) begin
        n_bad++;
        $display("FAIL rsp_hold valid=%b data=%h err=%b req_ready=%b want 1 %h %b 0",
                 rsp_valid, rsp_data, rsp_err, req_ready, d, e);
      end
    end
    rsp_ready = 1; #1;
    n_cmp++;
    if (req_ready) begin
      n_bad++;
      $display("FAIL take_cycle_ready req_ready=%b want 0", req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] d, input int hold,
                        output logic [W-1:0] rd, output logic re, output int lat,
                        output int de, output int dd);
    int e0 = n_enq, d0 = n_deq;
    accept(op, d);
    wait_rsp(lat);
    rd = rsp_data;
    re = rsp_err;
    de = n_enq - e0;
    dd = n_deq - d0;
    take_rsp(hold, rd, re);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, q_enq, q_deq, req_ready} !== 5'b0 || rsp_data !== '0 ||
        q_data_o !== '0 || cnt_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs valid=%b err=%b enq=%b deq=%b rdy=%b data=%h qd=%h cnt=%0d want all 0",
               rsp_valid, rsp_err, q_enq, q_deq, req_ready, rsp_data, q_data_o, cnt_o);
    end
    rst = 0; #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready req_ready=%b want 1", req_ready);
    end
    @(negedge clk); rdy_hold = 0; #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_follows_rdy req_ready=%b want 0", req_ready);
    end
    rdy_hold = 1;
  endtask

  task automatic check_op(input string nm, input logic op, input logic [W-1:0] d,
                          input int hold, input logic exact_lat);
    logic [W-1:0] rd, ed;
    logic re, ee;
    int lat, de, dd;
    ref_apply(op, d, ed, ee);
    run_op(op, d, hold, rd, re, lat, de, dd);
    n_cmp++;
    if (rd !== ed || re !== ee) begin
      n_bad++;
      $display("FAIL %s_rsp data=%h err=%b want %h %b", nm, rd, re, ed, ee);
    end
    n_cmp++;
    if (cnt_o !== CW'(ref_q.size())) begin
      n_bad++;
      $display("FAIL %s_cnt cnt=%0d want %0d", nm, cnt_o, ref_q.size());
    end
    n_cmp++;
    if (de !== ((op == OP_ENQ && !ee) ? 1 : 0) || dd !== ((op == OP_DEQ && !ee) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s_strobes enq=%0d deq=%0d op=%b err=%b", nm, de, dd, op, ee);
    end
    n_cmp++;
    if (ee ? lat != 2 : (exact_lat ? lat != 3 : lat < 3)) begin
      n_bad++;
      $display("FAIL %s_latency lat=%0d want %s", nm, lat, ee ? "2" : "3");
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] v[3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) check_op("basic_enq", OP_ENQ, v[i], 0, 1);
    for (int i = 0; i < 3; i++) check_op("basic_deq", OP_DEQ, $urandom, 0, 1);
  endtask

  task automatic test_empty_deq;
    check_op("empty_deq", OP_DEQ, 32'h0, 1, 1);
  endtask

  task automatic test_full;
    for (int i = 0; i < CAP; i++) check_op("fill", OP_ENQ, $urandom, 0, 1);
    check_op("full_enq", OP_ENQ, 32'hAA, 0, 1);
    for (int i = 0; i < CAP; i++) check_op("drain", OP_DEQ, $urandom, 0, 1);
  endtask

  task automatic test_settle_stall;
    logic [W-1:0] ed;
    logic ee;
    ref_apply(OP_ENQ, 32'hC3C3, ed, ee);
    accept(OP_ENQ, 32'hC3C3);
    @(negedge clk); #1;
    n_cmp++;
    if (q_enq !== 1'b1 || q_data_o !== 32'hC3C3) begin
      n_bad++;
      $display("FAIL stall_strobe enq=%b data=%h want 1 c3c3", q_enq, q_data_o);
    end
    rdy_hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (dut.state !== ST_SETTLE || req_ready || rsp_valid || q_enq || q_data_o !== '0) begin
        n_bad++;
        $display("FAIL stall_settle state=%0d rdy=%b valid=%b enq=%b qd=%h", dut.state,
                 req_ready, rsp_valid, q_enq, q_data_o);
      end
    end
    rdy_hold = 1;
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || cnt_o !== CW'(ref_q.size())) begin
      n_bad++;
      $display("FAIL stall_resp valid=%b err=%b cnt=%0d want 1 0 %0d", rsp_valid, rsp_err,
               cnt_o, ref_q.size());
    end
    take_rsp(0, '0, 1'b0);
    check_op("stall_deq", OP_DEQ, 32'h0, 0, 1);
  endtask

  task automatic test_rsp_hold;
    logic [W-1:0] ed;
    logic ee;
    int lat, d0;
    check_op("hold_enq", OP_ENQ, 32'h5A, 0, 1);
    ref_apply(OP_DEQ, 32'h0, ed, ee);
    accept(OP_DEQ, 32'h0);
    wait_rsp(lat);
    n_cmp++;
    if (rsp_data !== ed || rsp_err !== ee) begin
      n_bad++;
      $display("FAIL hold_data data=%h err=%b want %h %b", rsp_data, rsp_err, ed, ee);
    end
    d0 = n_deq;
    req_valid = 1; req_op = OP_DEQ;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (!rsp_valid || rsp_data !== 32'h5A || req_ready) begin
        n_bad++;
        $display("FAIL hold_stable valid=%b data=%h rdy=%b want 1 5a 0", rsp_valid, rsp_data, req_ready);
      end
    end
    req_valid = 0;
    take_rsp(0, 32'h5A, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (rsp_valid || n_deq != d0 || cnt_o !== '0) begin
      n_bad++;
      $display("FAIL hold_no_second valid=%b deqs=%0d cnt=%0d want 0 0 0", rsp_valid, n_deq - d0, cnt_o);
    end
  endtask

  task automatic test_reset_mid;
    int e0, d0;
    accept(OP_ENQ, 32'h77);
    @(negedge clk); #1;
    rdy_hold = 0;
    @(negedge clk); #1;
    rst = 1; #1;
    n_cmp++;
    if ({rsp_valid, rsp_err, q_enq, q_deq, req_ready} !== 5'b0 || rsp_data !== '0 ||
        q_data_o !== '0 || cnt_o !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs valid=%b err=%b enq=%b deq=%b rdy=%b data=%h qd=%h cnt=%0d want all 0",
               rsp_valid, rsp_err, q_enq, q_deq, req_ready, rsp_data, q_data_o, cnt_o);
    end
    ref_q.delete();
    @(negedge clk);
    rst = 0; rdy_hold = 1;
    e0 = n_enq; d0 = n_deq;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (rsp_valid || cnt_o !== '0 || n_enq != e0 || n_deq != d0) begin
        n_bad++;
        $display("FAIL midreset_quiet valid=%b cnt=%0d enqs=%0d deqs=%0d want 0", rsp_valid,
                 cnt_o, n_enq - e0, n_deq - d0);
      end
    end
  endtask

  task automatic test_random;
    rnd_on = 1;
    for (int i = 0; i < 80; i++)
      check_op("rand", $urandom_range(0, 1) == 1 ? OP_DEQ : OP_ENQ, $urandom,
               $urandom_range(0, 2), 0);
    rnd_on = 0;
    @(negedge clk);
  endtask

  task automatic test_monitor;
    n_cmp++;
    if (mon_bad != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusive overlaps=%0d want 0", mon_bad);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty_deq;
    test_full;
    test_settle_stall;
    test_rsp_hold;
    test_reset_mid;
    test_random;
    test_monitor;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
